// File: rtl/pc_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_decode
// Purpose  : Front end of the 31-instruction single-issue CPU. Holds the PC,
//            fetches each instruction over a req/ack handshake, latches it
//            into the instruction register and produces a one-hot decode for
//            the control unit. Advances the PC from the control unit's
//            next-PC select when the instruction completes.
// Ports    : clk, rst (async, active high)
//            imem_addr/imem_req/imem_ack/imem_rdata : instruction fetch port
//            ex_stall      : execute stage busy, hold the current instruction
//            mux41_signal  : next-PC select (00 +4, 01 jr, 10 branch, 11 jump)
//            rs_data       : jr target
//            pc, pc_plus4, instr, decoded_instr, instr_valid, illegal,
//            halted, retire_cnt : state and decode outputs
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      imem_addr,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             ex_stall,
  input  logic [1:0]       mux41_signal,
  input  logic [31:0]      rs_data,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      instr,
  output logic [31:0]      decoded_instr,
  output logic             instr_valid,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]      dec_raw;
  logic [31:0]      next_pc;
  logic [31:0]      br_off;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Decode: R-type selects by funct, everything else by opcode. Register and
  // shamt fields are don't-care. Bit 31 is never set.
  // --------------------------------------------------------------------------
  always_comb begin
    dec_raw = '0;
    if (instr_q[31:26] == 6'h00) begin
      case (instr_q[5:0])
        6'h20: dec_raw[0]  = 1'b1; // add
        6'h21: dec_raw[1]  = 1'b1; // addu
        6'h22: dec_raw[2]  = 1'b1; // sub
        6'h23: dec_raw[3]  = 1'b1; // subu
        6'h24: dec_raw[4]  = 1'b1; // and
        6'h25: dec_raw[5]  = 1'b1; // or
        6'h26: dec_raw[6]  = 1'b1; // xor
        6'h27: dec_raw[7]  = 1'b1; // nor
        6'h2A: dec_raw[8]  = 1'b1; // slt
        6'h2B: dec_raw[9]  = 1'b1; // sltu
        6'h00: dec_raw[10] = 1'b1; // sll (also nop)
        6'h02: dec_raw[11] = 1'b1; // srl
        6'h03: dec_raw[12] = 1'b1; // sra
        6'h04: dec_raw[13] = 1'b1; // sllv
        6'h06: dec_raw[14] = 1'b1; // srlv
        6'h07: dec_raw[15] = 1'b1; // srav
        6'h08: dec_raw[16] = 1'b1; // jr
        default: dec_raw = '0;
      endcase
    end else begin
      case (instr_q[31:26])
        6'h08: dec_raw[17] = 1'b1; // addi
        6'h09: dec_raw[18] = 1'b1; // addiu
        6'h0C: dec_raw[19] = 1'b1; // andi
        6'h0D: dec_raw[20] = 1'b1; // ori
        6'h0E: dec_raw[21] = 1'b1; // xori
        6'h0F: dec_raw[22] = 1'b1; // lui
        6'h23: dec_raw[23] = 1'b1; // lw
        6'h2B: dec_raw[24] = 1'b1; // sw
        6'h04: dec_raw[25] = 1'b1; // beq
        6'h05: dec_raw[26] = 1'b1; // bne
        6'h0A: dec_raw[27] = 1'b1; // slti
        6'h0B: dec_raw[28] = 1'b1; // sltiu
        6'h02: dec_raw[29] = 1'b1; // j
        6'h03: dec_raw[30] = 1'b1; // jal
        default: dec_raw = '0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Next-PC selection
  // --------------------------------------------------------------------------
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (mux41_signal)
      2'b00: next_pc = pc_plus4;
      2'b01: next_pc = rs_data;                  // low bits passed through as-is
      2'b10: next_pc = pc_plus4 + br_off;
      2'b11: next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Stall wins over illegal detection: nothing moves while stalled.
        if (!ex_stall) begin
          if (illegal) begin
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = FETCH;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pc            = pc_q;
  assign pc_plus4      = pc_q + 32'd4;
  assign imem_addr     = pc_q;
  assign instr         = instr_q;
  assign retire_cnt    = cnt_q;
  assign imem_req      = (state_q == FETCH);
  assign instr_valid   = (state_q == EXEC);
  assign halted        = (state_q == HALT);
  assign decoded_instr = instr_valid ? dec_raw : 32'd0;
  assign illegal       = instr_valid && (dec_raw == 32'd0);

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_decode
// Purpose  : Self-checking bench for pc_fetch_decode: directed vector table,
//            randomized legal instruction stream against a reference model,
//            and hand-written halt / reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_decode;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int          CNT_W    = 32;

  // Instruction encodings, index = decoded bit position.
  localparam int RFUN[17] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27,
                              'h2A, 'h2B, 'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h08};
  localparam int OPS[14]  = '{'h08, 'h09, 'h0C, 'h0D, 'h0E, 'h0F, 'h23, 'h2B,
                              'h04, 'h05, 'h0A, 'h0B, 'h02, 'h03};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      imem_addr;
  logic             imem_req;
  logic             imem_ack = 1'b0;
  logic [31:0]      imem_rdata = '0;
  logic             ex_stall = 1'b0;
  logic [1:0]       mux41_signal = 2'b00;
  logic [31:0]      rs_data = '0;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic [31:0]      instr;
  logic [31:0]      decoded_instr;
  logic             instr_valid;
  logic             illegal;
  logic             halted;
  logic [CNT_W-1:0] retire_cnt;

  pc_fetch_decode #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .ex_stall     (ex_stall),
    .mux41_signal (mux41_signal),
    .rs_data      (rs_data),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .instr        (instr),
    .decoded_instr(decoded_instr),
    .instr_valid  (instr_valid),
    .illegal      (illegal),
    .halted       (halted),
    .retire_cnt   (retire_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] m_instr;
  logic        m_halt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Search the opcode tables for a match; no match means illegal (0).
  function automatic logic [31:0] ref_decode(input logic [31:0] w);
    int op, fn;
    op = int'(w[31:26]);
    fn = int'(w[5:0]);
    if (op == 0) begin
      for (int i = 0; i < 17; i++) if (fn == RFUN[i]) return 32'd1 << i;
    end else begin
      for (int j = 0; j < 14; j++) if (op == OPS[j]) return 32'd1 << (17 + j);
    end
    return 32'd0;
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                           input logic [1:0] mux, input logic [31:0] rs);
    int off;
    case (mux)
      2'b00:   return p + 32'd4;
      2'b01:   return rs;
      2'b10: begin
        off = int'($signed(w[15:0]));
        return p + 32'd4 + 32'(off * 4);
      end
      default: return ((p + 32'd4) & 32'hF000_0000) | ({6'd0, w[25:0]} * 32'd4);
    endcase
  endfunction

  // Run one instruction starting at a negedge with the DUT in FETCH.
  task automatic do_instr(input logic [31:0] w, input logic [1:0] mux, input logic [31:0] rs,
                          input int dly, input int stl,
                          output logic [31:0] o_dec, output logic [31:0] o_pc4);
    logic [31:0] exp_dec, nxt;
    for (int d = 0; d < dly; d++) begin
      imem_ack = 1'b0; imem_rdata = $urandom;
      chk("req_wait", {31'd0, imem_req}, 32'd1);
      chk("addr_wait", imem_addr, m_pc);
      chk("instr_hold_wait", instr, m_instr);
      @(posedge clk); @(negedge clk);
    end
    imem_ack = 1'b1; imem_rdata = w;
    chk("req", {31'd0, imem_req}, 32'd1);
    chk("addr", imem_addr, m_pc);
    @(posedge clk); @(negedge clk);
    m_instr = w;
    // ack/rdata noise while in EXEC must be ignored
    imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
    mux41_signal = mux; rs_data = rs; ex_stall = (stl > 0);
    exp_dec = ref_decode(w);
    nxt     = ref_next(m_pc, w, mux, rs);
    o_dec = decoded_instr; o_pc4 = pc_plus4;
    chk("valid", {31'd0, instr_valid}, 32'd1);
    chk("instr", instr, w);
    chk("decode", decoded_instr, exp_dec);
    chk("illegal", {31'd0, illegal}, {31'd0, exp_dec == 32'd0});
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("req_exec", {31'd0, imem_req}, 32'd0);
    for (int s = 0; s < stl; s++) begin
      @(posedge clk); @(negedge clk);
      imem_rdata = $urandom;
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_pc", pc, m_pc);
      chk("stall_cnt", retire_cnt, m_cnt);
      chk("stall_dec", decoded_instr, exp_dec);
      chk("stall_instr", instr, w);
    end
    ex_stall = 1'b0;
    @(posedge clk); @(negedge clk);
    imem_ack = 1'b0;
    if (exp_dec == 32'd0) m_halt = 1'b1;
    else begin
      m_pc  = nxt;
      m_cnt = m_cnt + 32'd1;
    end
    chk("pc_after", pc, m_pc);
    chk("cnt_after", retire_cnt, m_cnt);
    chk("halted_after", {31'd0, halted}, {31'd0, m_halt});
    chk("req_after", {31'd0, imem_req}, {31'd0, !m_halt});
    chk("valid_after", {31'd0, instr_valid}, 32'd0);
    chk("dec_after", decoded_instr, 32'd0);
  endtask

  typedef struct {
    logic [31:0] w;
    logic [1:0]  mux;
    logic [31:0] rs;
    int          dly;
    int          stl;
    logic [31:0] dec;
    logic [31:0] pc4;
    logic [31:0] nxt;
  } vec_t;

  vec_t tbl[9];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] dec_o, pc4_o, w;
    logic [5:0]  f6;
    int          k;

    tbl[0] = '{32'h0043_0820, 2'b00, 32'h0,         0, 0, 32'h0000_0001, 32'h0040_0004, 32'h0040_0004}; // add
    tbl[1] = '{32'h0000_0000, 2'b00, 32'h0,         3, 0, 32'h0000_0400, 32'h0040_0008, 32'h0040_0008}; // nop, late ack
    tbl[2] = '{32'h03E0_0008, 2'b01, 32'h0040_0010, 0, 0, 32'h0001_0000, 32'h0040_000C, 32'h0040_0010}; // jr
    tbl[3] = '{32'h1000_FFFF, 2'b10, 32'h0,         0, 0, 32'h0200_0000, 32'h0040_0014, 32'h0040_0010}; // beq taken
    tbl[4] = '{32'h1000_FFFF, 2'b00, 32'h0,         1, 0, 32'h0200_0000, 32'h0040_0014, 32'h0040_0014}; // beq not taken
    tbl[5] = '{32'h03E0_0008, 2'b01, 32'h0040_0020, 0, 0, 32'h0001_0000, 32'h0040_0018, 32'h0040_0020}; // jr
    tbl[6] = '{32'h0C10_0008, 2'b11, 32'h0,         0, 0, 32'h4000_0000, 32'h0040_0024, 32'h0040_0020}; // jal
    tbl[7] = '{32'h03E0_0008, 2'b01, 32'h0040_0024, 0, 0, 32'h0001_0000, 32'h0040_0024, 32'h0040_0024}; // jr
    tbl[8] = '{32'h8C41_0004, 2'b00, 32'h0,         2, 4, 32'h0080_0000, 32'h0040_0028, 32'h0040_0028}; // lw stalled

    m_pc = RESET_PC; m_cnt = 0; m_instr = 0; m_halt = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_dec", decoded_instr, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);

    // IDLE for one cycle, then FETCH
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hFC00_0000; // ack outside FETCH is ignored
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("idle_instr", instr, 32'd0);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      do_instr(tbl[i].w, tbl[i].mux, tbl[i].rs, tbl[i].dly, tbl[i].stl, dec_o, pc4_o);
      chk("tbl_dec", dec_o, tbl[i].dec);
      chk("tbl_pc4", pc4_o, tbl[i].pc4);
      chk("tbl_next", pc, tbl[i].nxt);
    end
    chk("tbl_cnt", retire_cnt, 32'd9);

    // Randomized legal instruction stream
    for (int n = 0; n < 40; n++) begin
      w = $urandom;
      k = $urandom_range(0, 30);
      if (k < 17) begin
        f6 = 6'(RFUN[k]);
        w  = {6'd0, w[25:6], f6};
      end else begin
        f6 = 6'(OPS[k - 17]);
        w  = {f6, w[25:0]};
      end
      do_instr(w, 2'($urandom_range(0, 3)), $urandom,
               $urandom_range(0, 3), $urandom_range(0, 2), dec_o, pc4_o);
    end

    // Illegal instruction, stalled first: stall has priority
    do_instr(32'hFC00_0000, 2'b00, 32'h0, 0, 2, dec_o, pc4_o);
    repeat (2) @(negedge clk);
    chk("halt_sticky", {31'd0, halted}, 32'd1);
    chk("halt_req", {31'd0, imem_req}, 32'd0);
    chk("halt_pc", pc, m_pc);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", pc, RESET_PC);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    chk("arst_cnt", retire_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_pc = RESET_PC; m_cnt = 0; m_instr = 0; m_halt = 1'b0;
    chk("arst_idle_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("arst_fetch_req", {31'd0, imem_req}, 32'd1);

    // Reset during FETCH with an ack pending: fetch discarded
    imem_ack = 1'b1; imem_rdata = 32'h0043_0820;
    #2 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("fetch_rst_instr", instr, 32'd0);
    chk("fetch_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("fetch_rst_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b0; imem_ack = 1'b0;
    @(posedge clk); @(negedge clk);
    do_instr(32'h0043_0820, 2'b00, 32'h0, 0, 0, dec_o, pc4_o);
    chk("recover_cnt", retire_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
